// File: rtl/serial_pkg.sv
// Shared constants for the serial receive path: FSM state encoding,
// default bit period and 8N1 frame geometry.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned STOP_BITS            = 1;

endpackage : serial_pkg

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to a
// configurable value so an idle line never looks active out of reset.
module sync2 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make each flop capture the pre-edge value
  // of its source, which is what turns this into a two-stage pipeline.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync2

// File: rtl/serial_rx8.sv
// 8N1 serial receiver: mid-bit sampling FSM that assembles a byte and pulses
// LOAD for good frames or FRAME_ERR when the stop bit samples low.
module serial_rx8
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 LOAD,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_clks_per_bit
    $error("serial_rx8: CLKS_PER_BIT must be even and >= 4");
  end

  logic rs;

  sync2 #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_i(CLK),
    .rst_i(RESET),
    .d_i  (RX),
    .q_o  (rs)
  );

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [IW-1:0]        idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 load_q,  load_d;
  logic                 ferr_q,  ferr_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      load_q  <= load_d;
      ferr_q  <= ferr_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rs) state_d = ST_START;
      end
      ST_START: begin
        // Half a bit in: a still-low line is a real start bit, high was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rs, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rs) begin
            data_d  = shift_q;
            load_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line stays here so it reports one error, not one per frame time.
        cnt_d = '0;
        if (rs) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign DATA_OUT  = data_q;
  assign LOAD      = load_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule : serial_rx8

// File: doc/serial_rx8.md
# serial_rx8

Serial-to-parallel byte receiver: samples an asynchronous 8N1 serial line (1 start bit, 8 data bits LSB first, 1 stop bit) and assembles each frame into a byte. It sits directly upstream of the 8-bit holding register:

- DATA_OUT drives the register's data input.
- LOAD drives the register's load enable, as a single-cycle pulse per good frame.
- Framing errors are flagged and never loaded.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: CLK cycles per serial bit. Must be even and ≥ 4.

Ports:
- CLK  in  1  rising-edge clock (single clock domain).
- RESET  in  1  asynchronous, active-high reset.
- RX  in  1  serial line, asynchronous to CLK, idle high.
- DATA_OUT  out  8  last correctly received byte; held between frames.
- LOAD  out  1  one-cycle pulse when DATA_OUT takes a new byte.
- FRAME_ERR  out  1  one-cycle pulse when the stop bit samples low.
- BUSY  out  1  high whenever FSM is not in IDLE.

## Operation
- RX passes through a 2-flop synchronizer (flops reset to 1); the FSM sees only the synchronized bit rs.
- Let N = CLKS_PER_BIT and H = N/2. The baud counter is $clog2(N) bits wide and reloads on every state change.
- IDLE:
  - rs = 0 → START, counter cleared.
  - Otherwise stay in IDLE.
- START:
  - After H cycles, sample rs.
  - rs = 0 → DATA, bit index = 0.
  - rs = 1 (glitch) → IDLE silently, with no FRAME_ERR.
- DATA:
  - Every N cycles, sample rs into shift register bit 7 and shift right, so the first received bit ends in bit 0.
  - After the sample with bit index 7 → STOP.
  - The 3-bit index wraps 7→0 only on that exit.
- STOP: after N cycles, sample rs.
  - rs = 1: DATA_OUT ← shift register, LOAD = 1 for exactly one cycle, → IDLE.
  - rs = 0: FRAME_ERR = 1 for one cycle, DATA_OUT unchanged, → BREAK.
- BREAK: wait for rs = 1, then → IDLE. A line held low produces exactly one FRAME_ERR.
- LOAD and FRAME_ERR are never asserted in the same cycle.
- Back-to-back frames: a start edge is accepted in the first IDLE cycle after STOP.

## Timing
- Reset values:
  - Outputs: DATA_OUT = 8'h00, LOAD = 0, FRAME_ERR = 0, BUSY = 0.
  - Internal: FSM = IDLE, synchronizer = 1, counter, index and shift register = 0.
- Reset mid-frame aborts immediately. No LOAD or FRAME_ERR is emitted for the aborted frame.
- t0 is the first CLK edge at which the FSM, in IDLE, sees rs = 0. This is 2–3 cycles after RX falls.
  - Start-bit sample: t0 + H.
  - Data bit i sample (i = 0..7): t0 + H + (i+1)·N.
  - Stop sample: t0 + H + 9·N.
  - LOAD or FRAME_ERR is registered and high during the cycle after the stop-sample edge: t0 + H + 9·N + 1.
  - DATA_OUT changes on that same edge.
- BUSY rises at t0 + 1 and falls with the return to IDLE.

## Structure
- Shared package serial_pkg holds:
  - The FSM state encoding (IDLE, START, DATA, STOP, BREAK) as 3-bit constants.
  - The default bit-period constant.
  - The frame constants: 8 data bits and 1 stop bit.
- Sub-module sync2: 2-flop synchronizer with async active-high reset to a parameterised value (1 here). It is reused for other asynchronous inputs.
- The rest lives in one module: FSM, baud counter, bit index, shift register and output registers.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and drive RX at 16 CLK per bit.
- Reset then idle line: DATA_OUT = 00, LOAD/FRAME_ERR/BUSY = 0 for 500 cycles.
- Send frame 0xA5 → exactly one LOAD pulse at t0 + 153 with DATA_OUT = A5, FRAME_ERR stays 0, BUSY low afterwards.
- Send 0x3C then immediately 0xFF (no idle gap) → two LOAD pulses 160 cycles apart, DATA_OUT = 3C then FF.
- Glitch: RX low for 4 cycles only → FSM returns to IDLE, no LOAD, no FRAME_ERR, DATA_OUT unchanged.
- Send 0x81 with stop bit 0, then hold RX low 300 cycles → one FRAME_ERR pulse, DATA_OUT keeps its prior value, BUSY stays high until RX returns high.
- Assert RESET mid-way through data bit 4 of 0x55, then send a full 0x12 → no LOAD for 0x55, DATA_OUT = 00 after reset, then LOAD with DATA_OUT = 12.
